// File: rtl/day_rx.sv
// day_rx: assembles 4-bit letter codes into four-letter words and decodes day names.
// Optional weekly-order check (seq_err) is built when DAY_RX_SEQ_CHECK_EN is defined.
module day_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_first,
   input  logic [3:0] in_letter,
   output logic       day_valid,
   output logic       day_err,
   output logic [2:0] day_idx,
   output logic       frame_err,
   output logic       seq_err
);

   localparam logic [2:0] ERR_IDX = 3'b111;

   logic [1:0]  pos;
   logic [3:0]  slot0;
   logic [3:0]  slot1;
   logic [3:0]  slot2;
   logic [15:0] word;
   logic [3:0]  hit;
   logic        resync;
   logic        done;

   // {match, index}; words with illegal codes can never hit a table entry
   function automatic logic [3:0] lookup(input logic [15:0] w);
      case (w)
         16'h7787: lookup = 4'b1_000;
         16'hCD30: lookup = 4'b1_001;
         16'hDD32: lookup = 4'b1_010;
         16'hC5D0: lookup = 4'b1_011;
         16'h4A60: lookup = 4'b1_100;
         16'hB1C0: lookup = 4'b1_101;
         16'hBD70: lookup = 4'b1_110;
         default:  lookup = {1'b0, ERR_IDX};
      endcase
   endfunction

   assign resync = in_valid & in_first;
   assign done   = in_valid & ~in_first & (pos == 2'd3);
   // the 4th letter is matched straight off the bus, so it needs no slot
   assign word   = {slot0, slot1, slot2, in_letter};
   assign hit    = lookup(word);

   always_ff @(posedge clk) begin
      if (rst) begin
         pos       <= 2'd0;
         slot0     <= 4'd0;
         slot1     <= 4'd0;
         slot2     <= 4'd0;
         day_idx   <= ERR_IDX;
         day_valid <= 1'b0;
         day_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         day_valid <= 1'b0;
         day_err   <= 1'b0;
         frame_err <= 1'b0;
         if (resync) begin
            slot0     <= in_letter;
            pos       <= 2'd1;
            frame_err <= (pos != 2'd0);
         end else if (in_valid) begin
            unique case (pos)
               2'd0: slot0 <= in_letter;
               2'd1: slot1 <= in_letter;
               2'd2: slot2 <= in_letter;
               2'd3: ;
            endcase
            pos <= pos + 2'd1;
            if (done) begin
               day_valid <= hit[3];
               day_err   <= ~hit[3];
               day_idx   <= hit[2:0];
            end
         end
      end
   end

`ifdef DAY_RX_SEQ_CHECK_EN
   logic [2:0] last_idx;
   logic [2:0] succ;
   logic       have_last;

   assign succ = (last_idx == 3'd6) ? 3'd0 : last_idx + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_idx  <= 3'd0;
         have_last <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         seq_err <= 1'b0;
         if (done && hit[3]) begin
            seq_err   <= have_last && (hit[2:0] != succ);
            last_idx  <= hit[2:0];
            have_last <= 1'b1;
         end else if ((done && !hit[3]) || (resync && pos != 2'd0)) begin
            have_last <= 1'b0;
         end
      end
   end
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_day_rx.sv
// tb_day_rx: directed vector table plus randomized stream against a word-level model.
`timescale 1ns/1ps
module tb_day_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_first = 1'b0;
   logic [3:0] in_letter = 4'd0;
   logic       day_valid;
   logic       day_err;
   logic [2:0] day_idx;
   logic       frame_err;
   logic       seq_err;

   int n_run  = 0;
   int n_fail = 0;

`ifdef DAY_RX_SEQ_CHECK_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   always #5 clk = ~clk;

   day_rx dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_first(in_first),
      .in_letter(in_letter),
      .day_valid(day_valid),
      .day_err(day_err),
      .day_idx(day_idx),
      .frame_err(frame_err),
      .seq_err(seq_err)
   );

   typedef struct {
      bit         r;
      bit         v;
      bit         f;
      logic [3:0] l;
      bit         ev;
      bit         ee;
      logic [2:0] ei;
      bit         ef;
      bit         es;
   } vec_t;

   vec_t  tbl[$];
   string alpha = " ADEFHINOPRSTU";
   string days[7] = '{"NNON", "TUE ", "UUED", "THU ", "FRI ", "SAT ", "SUN "};

   function automatic logic [3:0] code(byte c);
      for (int i = 0; i < 14; i++)
         if (alpha[i] == c) return 4'(i);
      return 4'hF;
   endfunction

   function automatic void add(bit r, bit v, bit f, logic [3:0] l,
                               bit ev, bit ee, logic [2:0] ei, bit ef, bit es);
      vec_t x;
      x.r = r; x.v = v; x.f = f; x.l = l;
      x.ev = ev; x.ee = ee; x.ei = ei; x.ef = ef; x.es = es;
      tbl.push_back(x);
   endfunction

   function automatic void wrd(string s, logic [2:0] pi, bit ev, bit ee,
                               logic [2:0] ei, bit es);
      for (int k = 0; k < 3; k++) add(0, 1, 0, code(s[k]), 0, 0, pi, 0, 0);
      add(0, 1, 0, code(s[3]), ev, ee, ei, 0, es);
   endfunction

   task automatic apply(bit r, bit v, bit f, logic [3:0] l);
      rst = r; in_valid = v; in_first = f; in_letter = l;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, int n, logic [6:0] exp);
      logic [6:0] got;
      got = {day_valid, day_err, day_idx, frame_err, seq_err};
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s #%0d {valid,err,idx,frame,seq} got=%b expected=%b",
                  nm, n, got, exp);
      end
   endtask

   // word-level reference model
   logic [3:0] wq[$];
   bit         m_have;
   int         m_last;
   bit         mv, me, mf, ms;
   logic [2:0] mi = 3'd7;

   function automatic void model(bit r, bit v, bit f, logic [3:0] l);
      int hit;
      bit ok;
      mv = 0; me = 0; mf = 0; ms = 0;
      if (r) begin
         wq.delete(); m_have = 0; m_last = 0; mi = 3'd7;
         return;
      end
      if (!v) return;
      if (f) begin
         mf = (wq.size() != 0);
         if (mf) m_have = 0;
         wq.delete();
      end
      wq.push_back(l);
      if (wq.size() == 4) begin
         hit = -1;
         for (int d = 0; d < 7; d++) begin
            ok = 1;
            for (int k = 0; k < 4; k++)
               if (code(days[d][k]) !== wq[k]) ok = 0;
            if (ok) hit = d;
         end
         if (hit >= 0) begin
            mv = 1;
            mi = 3'(hit);
            ms = SEQ && m_have && (hit != (m_last + 1) % 7);
            m_have = 1;
            m_last = hit;
         end else begin
            me = 1;
            mi = 3'd7;
            m_have = 0;
         end
         wq.delete();
      end
   endfunction

   logic [3:0] gw[4];
   int         gp = 4;
   int         gd = 0;

   task automatic pick();
      if ($urandom_range(9) < 7) begin
         gd = ($urandom_range(1) == 1) ? (gd + 1) % 7 : int'($urandom_range(6));
         for (int k = 0; k < 4; k++) gw[k] = code(days[gd][k]);
      end else begin
         for (int k = 0; k < 4; k++) gw[k] = 4'($urandom_range(15));
      end
   endtask

   initial begin
      add(1, 0, 0, 0, 0, 0, 7, 0, 0);
      wrd("TUE ", 7, 1, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 7, 0, 0);
      wrd("SAT ", 7, 1, 0, 5, 0);
      wrd("SUN ", 5, 1, 0, 6, 0);
      wrd("NNON", 6, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 7, 0, 0);
      wrd("FRI ", 7, 1, 0, 4, 0);
      wrd("TUE ", 4, 1, 0, 1, SEQ);
      add(0, 1, 0, code("T"), 0, 0, 1, 0, 0);
      add(0, 1, 0, code("H"), 0, 0, 1, 0, 0);
      add(0, 1, 1, code("F"), 0, 0, 1, 1, 0);
      add(0, 1, 0, code("R"), 0, 0, 1, 0, 0);
      add(0, 1, 0, code("I"), 0, 0, 1, 0, 0);
      add(0, 1, 0, code(" "), 1, 0, 4, 0, 0);
      wrd("SAD ", 4, 0, 1, 7, 0);
      add(0, 1, 0, code("S"), 0, 0, 7, 0, 0);
      add(0, 1, 0, code("U"), 0, 0, 7, 0, 0);
      add(0, 1, 0, 4'hF,      0, 0, 7, 0, 0);
      add(0, 1, 0, code(" "), 0, 1, 7, 0, 0);
      add(0, 1, 1, code("N"), 0, 0, 7, 0, 0);
      add(0, 0, 0, 0,         0, 0, 7, 0, 0);
      add(0, 1, 0, code("N"), 0, 0, 7, 0, 0);
      add(0, 0, 0, 0,         0, 0, 7, 0, 0);
      add(0, 1, 0, code("O"), 0, 0, 7, 0, 0);
      add(1, 0, 0, 0,         0, 0, 7, 0, 0);
      wrd("NNON", 7, 1, 0, 0, 0);
      add(0, 0, 0, 0,         0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].l);
         check("vec", i, {tbl[i].ev, tbl[i].ee, tbl[i].ei, tbl[i].ef, tbl[i].es});
      end

      apply(1, 0, 0, 0);
      model(1, 0, 0, 0);
      check("rand_reset", 0, {mv, me, mi, mf, ms});
      for (int c = 0; c < 4000; c++) begin
         bit         r, v, f;
         logic [3:0] l;
         r = ($urandom_range(199) == 0);
         v = ($urandom_range(3) != 0);
         f = 0;
         l = 4'($urandom_range(15));
         if (v) begin
            if (gp >= 4) begin
               pick(); gp = 0; f = ($urandom_range(1) == 1);
            end else if ($urandom_range(24) == 0) begin
               pick(); gp = 0; f = 1;
            end
            l = gw[gp];
            gp++;
         end
         apply(r, v, f, l);
         model(r, v, f, l);
         check("rand", c, {mv, me, mi, mf, ms});
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
